// File: rtl/osd_regaccess_mux.sv
// Packet-atomic round-robin 2:1 merger of register-access responses and bypass
// traffic onto one registered DI link.
module osd_regaccess_mux (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_reg_data,
  input  logic        i_reg_last,
  input  logic        i_reg_valid,
  output logic        o_reg_ready,
  input  logic [15:0] i_bypass_data,
  input  logic        i_bypass_last,
  input  logic        i_bypass_valid,
  output logic        o_bypass_ready,
  output logic [15:0] o_out_data,
  output logic        o_out_last,
  output logic        o_out_valid,
  input  logic        i_out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REG    = 2'd1,
    ST_BYPASS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant_bypass;
  logic [15:0] r_out_data;
  logic        r_out_last;
  logic        r_out_valid;

  logic        w_grant_reg;
  logic        w_grant_bypass;
  logic        w_can_load;
  logic        w_xfer_reg;
  logic        w_xfer_bypass;

  // Effective grant: a packet in flight owns the link; otherwise round-robin on ties.
  always_comb begin
    w_grant_reg    = 1'b0;
    w_grant_bypass = 1'b0;
    case (r_state)
      ST_REG:    w_grant_reg    = 1'b1;
      ST_BYPASS: w_grant_bypass = 1'b1;
      ST_IDLE: begin
        if (i_reg_valid && i_bypass_valid) begin
          if (r_last_grant_bypass) begin
            w_grant_reg = 1'b1;
          end else begin
            w_grant_bypass = 1'b1;
          end
        end else if (i_reg_valid) begin
          w_grant_reg = 1'b1;
        end else if (i_bypass_valid) begin
          w_grant_bypass = 1'b1;
        end else begin
          w_grant_reg    = 1'b0;
          w_grant_bypass = 1'b0;
        end
      end
      default: begin
        w_grant_reg    = 1'b0;
        w_grant_bypass = 1'b0;
      end
    endcase
  end

  assign w_can_load     = ~r_out_valid | i_out_ready;
  assign o_reg_ready    = w_grant_reg & w_can_load;
  assign o_bypass_ready = w_grant_bypass & w_can_load;
  assign w_xfer_reg     = i_reg_valid & o_reg_ready;
  assign w_xfer_bypass  = i_bypass_valid & o_bypass_ready;

  // Next grant state: return to idle after the last flit of a packet.
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer_reg) begin
      w_state_nxt = i_reg_last ? ST_IDLE : ST_REG;
    end else if (w_xfer_bypass) begin
      w_state_nxt = i_bypass_last ? ST_IDLE : ST_BYPASS;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, round-robin history and the output flit register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state             <= ST_IDLE;
      r_last_grant_bypass <= 1'b1;
      r_out_data          <= 16'h0000;
      r_out_last          <= 1'b0;
      r_out_valid         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer_reg) begin
        r_out_data          <= i_reg_data;
        r_out_last          <= i_reg_last;
        r_out_valid         <= 1'b1;
        r_last_grant_bypass <= 1'b0;
      end else if (w_xfer_bypass) begin
        r_out_data          <= i_bypass_data;
        r_out_last          <= i_bypass_last;
        r_out_valid         <= 1'b1;
        r_last_grant_bypass <= 1'b1;
      end else if (w_can_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_osd_regaccess_mux.sv
// Directed bench for osd_regaccess_mux with hand-computed expectations.
module tb_osd_regaccess_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] reg_data;
  logic        reg_last;
  logic        reg_valid;
  logic        reg_ready;
  logic [15:0] byp_data;
  logic        byp_last;
  logic        byp_valid;
  logic        byp_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  osd_regaccess_mux dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_reg_data     (reg_data),
    .i_reg_last     (reg_last),
    .i_reg_valid    (reg_valid),
    .o_reg_ready    (reg_ready),
    .i_bypass_data  (byp_data),
    .i_bypass_last  (byp_last),
    .i_bypass_valid (byp_valid),
    .o_bypass_ready (byp_ready),
    .o_out_data     (out_data),
    .o_out_last     (out_last),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic l, input logic [15:0] d);
    chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
    if (v) begin
      chk({tag, ".last"}, {15'd0, out_last}, {15'd0, l});
      chk({tag, ".data"}, out_data, d);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic r, input logic b);
    #1;
    chk({tag, ".reg_ready"}, {15'd0, reg_ready}, {15'd0, r});
    chk({tag, ".byp_ready"}, {15'd0, byp_ready}, {15'd0, b});
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    reg_data = 16'h0000; reg_last = 1'b0; reg_valid = 1'b0;
    byp_data = 16'h0000; byp_last = 1'b0; byp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", {15'd0, out_valid}, 16'd0);
    chk("rst.last", {15'd0, out_last}, 16'd0);
    chk("rst.data", out_data, 16'h0000);
    chk_rdy("rst", 1'b0, 1'b0);

    // single source, 3-flit reg packet
    reg_valid = 1'b1; reg_data = 16'h0123; reg_last = 1'b0;
    chk_rdy("s1", 1'b1, 1'b0);
    tick(); chk_out("s1.o0", 1'b1, 1'b0, 16'h0123);
    reg_data = 16'h4567;
    chk_rdy("s2", 1'b1, 1'b0);
    tick(); chk_out("s1.o1", 1'b1, 1'b0, 16'h4567);
    reg_data = 16'h89AB; reg_last = 1'b1;
    chk_rdy("s3", 1'b1, 1'b0);
    tick(); chk_out("s1.o2", 1'b1, 1'b1, 16'h89AB);
    reg_valid = 1'b0;
    chk_rdy("s4", 1'b0, 1'b0);
    tick(); chk_out("s1.idle", 1'b0, 1'b0, 16'h0000);

    // tie after reset: reg wins
    rst = 1'b1; tick(); rst = 1'b0;
    reg_valid = 1'b1; reg_data = 16'h1000; reg_last = 1'b0;
    byp_valid = 1'b1; byp_data = 16'h2000; byp_last = 1'b0;
    chk_rdy("t0", 1'b1, 1'b0);
    tick(); chk_out("t.o0", 1'b1, 1'b0, 16'h1000);
    reg_data = 16'h1001; reg_last = 1'b1;
    chk_rdy("t1", 1'b1, 1'b0);
    tick(); chk_out("t.o1", 1'b1, 1'b1, 16'h1001);
    reg_valid = 1'b0;
    chk_rdy("t2", 1'b0, 1'b1);
    tick(); chk_out("t.o2", 1'b1, 1'b0, 16'h2000);
    byp_data = 16'h2001; byp_last = 1'b1;
    tick(); chk_out("t.o3", 1'b1, 1'b1, 16'h2001);
    byp_valid = 1'b0;
    tick(); chk_out("t.idle", 1'b0, 1'b0, 16'h0000);

    // fairness with single-flit packets
    reg_valid = 1'b1; reg_data = 16'h000A; reg_last = 1'b1;
    byp_valid = 1'b1; byp_data = 16'h000B; byp_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 1'b1, (i % 2 == 0) ? 16'h000A : 16'h000B);
    end
    reg_valid = 1'b0; byp_valid = 1'b0;
    tick(); chk_out("rr.idle", 1'b0, 1'b0, 16'h0000);

    // mid-packet bubble on bypass
    byp_valid = 1'b1; byp_data = 16'h3000; byp_last = 1'b0;
    chk_rdy("b0", 1'b0, 1'b1);
    tick(); chk_out("b.o0", 1'b1, 1'b0, 16'h3000);
    byp_valid = 1'b0;
    reg_valid = 1'b1; reg_data = 16'h4000; reg_last = 1'b1;
    chk_rdy("b1", 1'b0, 1'b1);
    tick(); chk_out("b.gap1", 1'b0, 1'b0, 16'h0000);
    chk_rdy("b2", 1'b0, 1'b1);
    tick(); chk_out("b.gap2", 1'b0, 1'b0, 16'h0000);
    byp_valid = 1'b1; byp_data = 16'h3001; byp_last = 1'b1;
    chk_rdy("b3", 1'b0, 1'b1);
    tick(); chk_out("b.o1", 1'b1, 1'b1, 16'h3001);
    byp_valid = 1'b0;
    chk_rdy("b4", 1'b1, 1'b0);
    tick(); chk_out("b.reg", 1'b1, 1'b1, 16'h4000);
    reg_valid = 1'b0;

    // backpressure
    reg_valid = 1'b1; reg_data = 16'h5555; reg_last = 1'b0;
    tick(); chk_out("p.o0", 1'b1, 1'b0, 16'h5555);
    out_ready = 1'b0;
    reg_data = 16'h6666; reg_last = 1'b1;
    byp_valid = 1'b1; byp_data = 16'h7777; byp_last = 1'b1;
    chk_rdy("p.hold", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("p.h%0d", i), 1'b1, 1'b0, 16'h5555);
      chk_rdy($sformatf("p.h%0d", i), 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    chk_rdy("p.rel", 1'b1, 1'b0);
    tick(); chk_out("p.o1", 1'b1, 1'b1, 16'h6666);
    reg_valid = 1'b0;
    chk_rdy("p.byp", 1'b0, 1'b1);
    tick(); chk_out("p.o2", 1'b1, 1'b1, 16'h7777);
    byp_valid = 1'b0;
    tick(); chk_out("p.idle", 1'b0, 1'b0, 16'h0000);

    // reset mid-packet
    byp_valid = 1'b1; byp_data = 16'h8000; byp_last = 1'b0;
    tick(); chk_out("r.o0", 1'b1, 1'b0, 16'h8000);
    byp_data = 16'h8001; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r.valid", {15'd0, out_valid}, 16'd0);
    chk("r.data", out_data, 16'h0000);
    byp_data = 16'h8002; byp_last = 1'b1;
    reg_valid = 1'b1; reg_data = 16'h9000; reg_last = 1'b1;
    chk_rdy("r.tie", 1'b1, 1'b0);
    tick(); chk_out("r.reg", 1'b1, 1'b1, 16'h9000);
    reg_valid = 1'b0;
    chk_rdy("r.byp", 1'b0, 1'b1);
    tick(); chk_out("r.byp", 1'b1, 1'b1, 16'h8002);
    byp_valid = 1'b0;
    tick(); chk_out("r.idle", 1'b0, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_regaccess_mux.md
# osd_regaccess_mux

Packet-atomic 2:1 merger for Debug Interconnect (DI) links. Combines register-access response packets with bypass traffic (events, traces, forwarded packets) onto one outgoing DI link. It is the egress counterpart of the register-access demultiplexer in a debug module's register-access layer. A packet is never interleaved with another. Arbitration between the two sources is round-robin at packet granularity. The output is registered.

## Interface
- No parameters.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_reg  in  dii_flit (data[15:0], last, valid)  register-access response packets.
- in_reg_ready  out  1  flit on in_reg is accepted this cycle.
- in_bypass  in  dii_flit  bypass packets.
- in_bypass_ready  out  1  flit on in_bypass is accepted this cycle.
- out  out  dii_flit  merged DI output, driven from a register.
- out_ready  in  1  downstream accepts out this cycle.

## Operation
- Grant state machine: IDLE, REG, BYPASS. There is also a 1-bit last_grant (REG/BYPASS).
- Effective grant (combinational):
  - If the state is REG or BYPASS, the grant is that state.
  - If the state is IDLE and only one input is valid, that input is granted.
  - If the state is IDLE and both inputs are valid, the input other than last_grant is granted.
  - If the state is IDLE and neither input is valid, there is no grant.
- Output stage:
  - A single flit register: out.data, out.last, out.valid.
  - can_load = !out.valid | out_ready.
- Ready signals:
  - in_reg_ready = (grant==REG) & can_load.
  - in_bypass_ready = (grant==BYPASS) & can_load.
  - The non-granted input's ready is always 0.
- Transfer on the granted input = valid & ready. On a transfer:
  - The flit (data, last) is copied into the output register and out.valid is set to 1.
  - last_grant is set to the granted source.
  - If flit.last = 1, the state goes to IDLE. Otherwise the state goes to the granted source (REG or BYPASS).
- If can_load holds and there is no transfer, out.valid is set to 0.
- If can_load does not hold, the output register holds its contents.
- Packet atomicity:
  - While the state is REG or BYPASS, the grant holds until that source's last flit transfers.
  - This applies even if the granted source goes invalid mid-packet (bubble), and even if the other input is valid.
- Single-flit packets (last on the first flit) go from IDLE back to IDLE directly. The next packet can be granted in the following cycle.
- data is forwarded unmodified. The mux inspects no header fields.

## Timing
- Reset values:
  - out.valid = 0, out.last = 0, out.data = 0.
  - State = IDLE.
  - last_grant = BYPASS, so in_reg wins the first tie.
  - in_reg_ready and in_bypass_ready: 0 unless a valid input exists and the output register is empty. They are then derived combinationally in the first cycle after reset.
- Latency: a flit accepted in cycle N appears on out in cycle N+1.
- Throughput: 1 flit/cycle while out_ready stays high.
- The ready signals are combinational from in_*.valid (only in IDLE), the state, out.valid and out_ready. There is no combinational path from in_*.data to any output.
- Output hold: while out.valid=1 and out_ready=0, out.data, out.last and out.valid are stable, and both input readies are 0.
- Simultaneous packet end and new request: a flit with last transfers in cycle N. A request pending in N+1 is arbitrated in N+1 using the updated last_grant.
- Reset mid-packet: the state returns to IDLE and out.valid is cleared. The partial packet is discarded with no error signalling.
- Input valid must stay asserted until accepted. This is an upstream obligation and is not checked.

## Test plan
- Single source: in_reg sends 3 flits (0x0123, 0x4567, 0x89AB with last), out_ready=1.
  - out shows the same 3 flits in cycles N+1..N+3, with last only on 0x89AB.
  - in_bypass_ready stays 0 throughout.
- Tie after reset: both inputs present a 2-flit packet in the same cycle (reg 0x1000/0x1001, bypass 0x2000/0x2001).
  - out shows 0x1000, 0x1001, 0x2000, 0x2001 with no gap.
  - The bypass packet starts on out exactly 1 cycle after 0x1001.
- Fairness: both sources continuously offer single-flit packets (reg 0xA, bypass 0xB) for 8 cycles.
  - out alternates A, B, A, B, …, starting with A.
- Mid-packet bubble: bypass sends 0x3000, then drops valid for 2 cycles, then sends 0x3001 with last. in_reg is valid throughout.
  - in_reg_ready stays 0 until 0x3001 transfers.
  - The reg flit appears on out right after 0x3001.
- Backpressure: out_ready=0 for 4 cycles while out holds 0x5555.
  - out stays stable and both readies are 0.
  - When out_ready rises, the next flit loads in the same cycle and appears 1 cycle later.
- Reset mid-packet: assert rst after the first flit of a 3-flit bypass packet.
  - The next cycle shows out.valid=0 and state IDLE.
  - A new in_reg single-flit packet is then granted first and appears on out 1 cycle after acceptance.
